multicycle_main_control: RTL and testbench

- Moore-style main control FSM for the multicycle MIPS datapath. Sits directly upstream of the ALU control decoder.
- Decodes the 6-bit opcode from the instruction register and sequences fetch, decode, execute, memory and writeback.
- Drives AluOp (00 add, 01 sub/compare, 10 use funct field) plus all datapath mux selects and write enables.
- Stalls on a memory-ready handshake.

---
 rtl/multicycle_main_control.sv | 185 ++++++++++++++++++
 tb/tb_multicycle_main_control.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_control.sv
// Moore main-control FSM for the multicycle MIPS datapath (fetch/decode/execute/memory/writeback).
// Optional feature: define MC_ADDI_EN to implement the addi path (ADDIEX -> ADDIWB).
module multicycle_main_control #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Op,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               IRWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         AluOp,
    output logic               AluSrcA,
    output logic [1:0]         AluSrcB,
    output logic               RegWrite,
    output logic               RegDst,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_out
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXEC   = STATE_W'(6),
        RWB    = STATE_W'(7),
        BEQ    = STATE_W'(8),
        JUMP   = STATE_W'(9),
        ADDIEX = STATE_W'(10),
        ADDIWB = STATE_W'(11)
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_e state_q;
    state_e state_d;

    // State register, asynchronously returned to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode; everything is forced low while reset is held
    // so no write strobe survives reset assertion.
    always_comb begin
        state_d     = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        AluOp       = 2'b00;
        AluSrcA     = 1'b0;
        AluSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        illegal_op  = 1'b0;
        state_out   = {STATE_W{1'b0}};
        if (reset) begin
            state_d = FETCH;
        end else begin
            state_out = state_q;
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    AluSrcB = 2'b01;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready) begin
                        state_d = DECODE;
                    end else begin
                        state_d = FETCH;
                    end
                end
                DECODE: begin
                    AluSrcB = 2'b11;
                    case (Op)
                        OP_RTYPE: state_d = EXEC;
                        OP_LW:    state_d = MEMADR;
                        OP_SW:    state_d = MEMADR;
                        OP_BEQ:   state_d = BEQ;
                        OP_J:     state_d = JUMP;
`ifdef MC_ADDI_EN
                        OP_ADDI:  state_d = ADDIEX;
`endif
                        default: begin
                            state_d    = FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                MEMADR: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    if (Op == OP_LW) begin
                        state_d = MEMRD;
                    end else begin
                        state_d = MEMWR;
                    end
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) begin
                        state_d = MEMWB;
                    end else begin
                        state_d = MEMRD;
                    end
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    state_d  = FETCH;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = MEMWR;
                    end
                end
                EXEC: begin
                    AluSrcA = 1'b1;
                    AluOp   = 2'b10;
                    state_d = RWB;
                end
                RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    state_d  = FETCH;
                end
                BEQ: begin
                    AluSrcA     = 1'b1;
                    AluOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                    state_d     = FETCH;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                    state_d  = FETCH;
                end
`ifdef MC_ADDI_EN
                ADDIEX: begin
                    AluSrcA = 1'b1;
                    AluSrcB = 2'b10;
                    state_d = ADDIWB;
                end
                ADDIWB: begin
                    RegWrite = 1'b1;
                    state_d  = FETCH;
                end
`endif
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_main_control.sv
// Scoreboard bench for multicycle_main_control: stimulus pushes hand-computed output vectors,
// a monitor pops and compares one vector per cycle.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, AluOp, AluSrcB;
    logic       AluSrcA, RegWrite, RegDst, illegal_op;
    logic [3:0] state_out;

    multicycle_main_control #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .PCSource(PCSource), .AluOp(AluOp),
        .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // Vector: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,MemtoReg,IRWrite,PCSource,AluOp,AluSrcA,AluSrcB,RegWrite,RegDst,illegal_op,state
    localparam logic [20:0] V_ZERO   = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 4'd0};
    localparam logic [20:0] V_FETCH1 = {7'b1001001, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 4'd0};
    localparam logic [20:0] V_FETCH0 = {7'b0001000, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 4'd0};
    localparam logic [20:0] V_DEC    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b000, 4'd1};
    localparam logic [20:0] V_DECILL = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b11, 3'b001, 4'd1};
    localparam logic [20:0] V_MEMADR = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000, 4'd2};
    localparam logic [20:0] V_MEMRD  = {7'b0011000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 4'd3};
    localparam logic [20:0] V_MEMWB  = {7'b0000010, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100, 4'd4};
    localparam logic [20:0] V_MEMWR  = {7'b0010100, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 4'd5};
    localparam logic [20:0] V_EXEC   = {7'b0000000, 2'b00, 2'b10, 1'b1, 2'b00, 3'b000, 4'd6};
    localparam logic [20:0] V_RWB    = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b110, 4'd7};
    localparam logic [20:0] V_BEQ    = {7'b0100000, 2'b01, 2'b01, 1'b1, 2'b00, 3'b000, 4'd8};
    localparam logic [20:0] V_JUMP   = {7'b1000000, 2'b10, 2'b00, 1'b0, 2'b00, 3'b000, 4'd9};
    localparam logic [20:0] V_ADDIEX = {7'b0000000, 2'b00, 2'b00, 1'b1, 2'b10, 3'b000, 4'd10};
    localparam logic [20:0] V_ADDIWB = {7'b0000000, 2'b00, 2'b00, 1'b0, 2'b00, 3'b100, 4'd11};

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    logic [20:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;
    logic        stim_done = 1'b0;

    wire [20:0] act_v = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                         PCSource, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst, illegal_op, state_out};

    // One cycle of stimulus: drive inputs after the falling edge and record the expected outputs.
    task automatic step(input string nm, input logic rst_v, input logic [5:0] op_v,
                        input logic mr_v, input logic [20:0] ev);
        @(negedge clk);
        reset     = rst_v;
        Op        = op_v;
        mem_ready = mr_v;
        exp_q.push_back(ev);
        name_q.push_back(nm);
    endtask

    // Monitor: compare the settled outputs a few ns after each falling edge.
    initial begin
        logic [20:0] ev;
        string       nm;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                nm = name_q.pop_front();
                total = total + 1;
                if (act_v !== ev) begin
                    bad = bad + 1;
                    $display("FAIL %s actual=%b required=%b", nm, act_v, ev);
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        Op        = OP_R;
        mem_ready = 1'b1;
        step("rst_a", 1'b1, OP_R, 1'b1, V_ZERO);
        step("rst_b", 1'b1, OP_R, 1'b1, V_ZERO);
        // fetch stall, then R-type 0,1,6,7,0
        step("r_fetch_stall", 1'b0, OP_R, 1'b0, V_FETCH0);
        step("r_fetch", 1'b0, OP_R, 1'b1, V_FETCH1);
        step("r_dec",   1'b0, OP_R, 1'b1, V_DEC);
        step("r_exec",  1'b0, OP_R, 1'b1, V_EXEC);
        step("r_rwb",   1'b0, OP_R, 1'b1, V_RWB);
        // lw with two stall cycles in MEMRD
        step("lw_fetch", 1'b0, OP_LW, 1'b1, V_FETCH1);
        step("lw_dec",   1'b0, OP_LW, 1'b1, V_DEC);
        step("lw_adr",   1'b0, OP_LW, 1'b1, V_MEMADR);
        step("lw_rd_s1", 1'b0, OP_LW, 1'b0, V_MEMRD);
        step("lw_rd_s2", 1'b0, OP_LW, 1'b0, V_MEMRD);
        step("lw_rd",    1'b0, OP_LW, 1'b1, V_MEMRD);
        step("lw_wb",    1'b0, OP_LW, 1'b1, V_MEMWB);
        // beq, j
        step("beq_fetch", 1'b0, OP_BEQ, 1'b1, V_FETCH1);
        step("beq_dec",   1'b0, OP_BEQ, 1'b1, V_DEC);
        step("beq_ex",    1'b0, OP_BEQ, 1'b1, V_BEQ);
        step("j_fetch",   1'b0, OP_J, 1'b1, V_FETCH1);
        step("j_dec",     1'b0, OP_J, 1'b1, V_DEC);
        step("j_ex",      1'b0, OP_J, 1'b1, V_JUMP);
        // illegal opcode: one-cycle flag then back to FETCH
        step("ill_fetch", 1'b0, OP_BAD, 1'b1, V_FETCH1);
        step("ill_dec",   1'b0, OP_BAD, 1'b1, V_DECILL);
        // addi
        step("addi_fetch", 1'b0, OP_ADDI, 1'b1, V_FETCH1);
`ifdef MC_ADDI_EN
        step("addi_dec",   1'b0, OP_ADDI, 1'b1, V_DEC);
        step("addi_ex",    1'b0, OP_ADDI, 1'b1, V_ADDIEX);
        step("addi_wb",    1'b0, OP_ADDI, 1'b1, V_ADDIWB);
`else
        step("addi_dec",   1'b0, OP_ADDI, 1'b1, V_DECILL);
`endif
        // sw with one stall in MEMWR
        step("sw_fetch", 1'b0, OP_SW, 1'b1, V_FETCH1);
        step("sw_dec",   1'b0, OP_SW, 1'b1, V_DEC);
        step("sw_adr",   1'b0, OP_SW, 1'b1, V_MEMADR);
        step("sw_wr_s",  1'b0, OP_SW, 1'b0, V_MEMWR);
        step("sw_wr",    1'b0, OP_SW, 1'b1, V_MEMWR);
        // reset asserted while MemWrite is held in MEMWR
        step("rw_fetch", 1'b0, OP_SW, 1'b1, V_FETCH1);
        step("rw_dec",   1'b0, OP_SW, 1'b1, V_DEC);
        step("rw_adr",   1'b0, OP_SW, 1'b1, V_MEMADR);
        step("rw_wr",    1'b0, OP_SW, 1'b0, V_MEMWR);
        step("rw_rst",   1'b1, OP_SW, 1'b0, V_ZERO);
        step("rw_post",  1'b0, OP_SW, 1'b1, V_FETCH1);
        step("rw_dec2",  1'b0, OP_SW, 1'b1, V_DEC);
        @(negedge clk);
        #5;
        stim_done = 1'b1;
    end

    // Summary once stimulus is drained, with a hard time bound.
    initial begin
        fork
            begin
                wait (stim_done);
            end
            begin
                #20000;
                total = total + 1;
                bad   = bad + 1;
                $display("FAIL timeout actual=not_done required=done");
            end
        join_any
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
